// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants and types for the ALU sharing arbiter.
package alu_share_arbiter_pkg;

    localparam int unsigned DATA_W = 32;

    // ALU control codes; anything above ALU_CTRL_MAX is treated as illegal.
    localparam logic [3:0] ALU_ADD      = 4'd0;
    localparam logic [3:0] ALU_SUB      = 4'd1;
    localparam logic [3:0] ALU_AND      = 4'd2;
    localparam logic [3:0] ALU_XOR      = 4'd3;
    localparam logic [3:0] ALU_OR       = 4'd4;
    localparam logic [3:0] ALU_SLL      = 4'd5;
    localparam logic [3:0] ALU_SRL      = 4'd6;
    localparam logic [3:0] ALU_SLT      = 4'd7;
    localparam logic [3:0] ALU_SLTU     = 4'd8;
    localparam logic [3:0] ALU_CTRL_MAX = ALU_SLTU;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    function automatic logic is_illegal(input logic [3:0] ctrl);
        return ctrl > ALU_CTRL_MAX;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between requesters, consumer and the ALU arbiter.
interface alu_share_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ*4-1:0]  req_ctrl;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_result;
    logic                  rsp_carryout;
    logic                  rsp_overflow;
    logic                  rsp_zero;
    logic                  rsp_illegal;
    logic                  busy;
    logic [31:0]           op_count;

    // Requester/consumer side.
    modport master (
        output req_valid, req_a, req_b, req_ctrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_carryout,
        input  rsp_overflow, rsp_zero, rsp_illegal, busy, op_count
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_carryout,
        output rsp_overflow, rsp_zero, rsp_illegal, busy, op_count
    );
endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU: add/sub/and/xor/or/sll/srl/slt/sltu.
module alu
    import alu_share_arbiter_pkg::*;
(
    input  logic [3:0]  ctrl_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o,
    output logic        carryout_o,
    output logic        overflow_o,
    output logic        zero_o
);
    logic [32:0] sum;
    logic [32:0] diff;

    // Decode the operation; carry/overflow are only meaningful for add and sub.
    always_comb begin
        sum        = {1'b0, a_i} + {1'b0, b_i};
        diff       = {1'b0, a_i} + {1'b0, ~b_i} + 33'd1;
        result_o   = '0;
        carryout_o = 1'b0;
        overflow_o = 1'b0;
        case (ctrl_i)
            ALU_ADD: begin
                result_o   = sum[31:0];
                carryout_o = sum[32];
                overflow_o = (a_i[31] == b_i[31]) && (sum[31] != a_i[31]);
            end
            ALU_SUB: begin
                // Carry is the inverted borrow: set when a >= b unsigned.
                result_o   = diff[31:0];
                carryout_o = diff[32];
                overflow_o = (a_i[31] != b_i[31]) && (diff[31] != a_i[31]);
            end
            ALU_AND:  result_o = a_i & b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_SLL:  result_o = a_i << b_i[4:0];
            ALU_SRL:  result_o = a_i >> b_i[4:0];
            ALU_SLT:  result_o = {31'd0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {31'd0, a_i < b_i};
            default:  result_o = '0;
        endcase
        zero_o = (result_o == 32'd0);
    end

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted request at or above the pointer, with wrap.
module alu_share_arbiter_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);
    int unsigned cand;
    logic        found;

    // Scan all requesters starting at the pointer; the first hit wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = (32'(ptr_i) + off) % NUM_REQ;
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                idx_o       = ID_W'(cand);
                gnt_o[cand] = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NUM_REQ requesters: grant, execute, hold response.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    alu_share_arbiter_if.slave  bus_io
);
    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [31:0]         a_q, a_d;
    logic [31:0]         b_q, b_d;
    logic [3:0]          ctrl_q, ctrl_d;
    logic [31:0]         result_q, result_d;
    logic                carry_q, carry_d;
    logic                ovf_q, ovf_d;
    logic                zero_q, zero_d;
    logic                illegal_q, illegal_d;
    logic [31:0]         count_q, count_d;
    logic [NUM_REQ-1:0]  req_ready;

    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic                gnt_any;

    logic [31:0]         alu_result;
    logic                alu_carry;
    logic                alu_ovf;
    logic                alu_zero;

    alu_share_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req_i (bus_io.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    alu u_alu (
        .ctrl_i     (ctrl_q),
        .a_i        (a_q),
        .b_i        (b_q),
        .result_o   (alu_result),
        .carryout_o (alu_carry),
        .overflow_o (alu_ovf),
        .zero_o     (alu_zero)
    );

    // Next-state: grant in idle, capture ALU outputs in exec, wait for consumer in resp.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        ctrl_d    = ctrl_q;
        result_d  = result_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        count_d   = count_q;
        req_ready = '0;
        unique case (state_q)
            StIdle: begin
                if (gnt_any && !rst) begin
                    // Granted valid is always ready, so a grant is a handshake.
                    req_ready = gnt;
                    a_d       = bus_io.req_a[32*gnt_idx +: 32];
                    b_d       = bus_io.req_b[32*gnt_idx +: 32];
                    ctrl_d    = bus_io.req_ctrl[4*gnt_idx +: 4];
                    id_d      = gnt_idx;
                    ptr_d     = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d   = StExec;
                end
            end
            StExec: begin
                result_d  = alu_result;
                carry_d   = alu_carry;
                ovf_d     = alu_ovf;
                zero_d    = alu_zero;
                illegal_d = is_illegal(ctrl_q);
                state_d   = StResp;
            end
            StResp: begin
                if (bus_io.rsp_ready) begin
                    count_d = count_q + 32'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= '0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ctrl_q    <= ctrl_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    assign bus_io.req_ready    = req_ready;
    assign bus_io.rsp_valid    = (state_q == StResp);
    assign bus_io.rsp_id       = id_q;
    assign bus_io.rsp_result   = result_q;
    assign bus_io.rsp_carryout = carry_q;
    assign bus_io.rsp_overflow = ovf_q;
    assign bus_io.rsp_zero     = zero_q;
    assign bus_io.rsp_illegal  = illegal_q;
    assign bus_io.busy         = (state_q != StIdle);
    assign bus_io.op_count     = count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench: directed vector table, multi-cycle sequences, random ops vs model.
module tb_alu_share_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
        logic        ill;
    } exp_t;

    typedef struct {
        int unsigned id;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        int unsigned hold;
        exp_t        ex;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned m_ptr   = 0;
    int unsigned m_count = 0;

    logic [31:0] da [NUM_REQ];
    logic [31:0] db [NUM_REQ];
    logic [3:0]  dc [NUM_REQ];

    vec_t vecs[$];

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    alu_share_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference ALU from the operation definitions, using 64-bit arithmetic.
    function automatic exp_t model_alu(input logic [3:0] ctrl, input logic [31:0] a,
                                       input logic [31:0] b);
        exp_t e;
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint          sr;
        e.res = '0; e.c = 1'b0; e.v = 1'b0; e.ill = 1'b0;
        case (ctrl)
            4'd0: begin
                e.res = 32'(ua + ub);
                e.c   = (ua + ub) > 64'hFFFF_FFFF;
                sr    = sa + sb;
                e.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd1: begin
                e.res = 32'(ua - ub);
                e.c   = (ua >= ub);
                sr    = sa - sb;
                e.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd2: e.res = a & b;
            4'd3: e.res = a ^ b;
            4'd4: e.res = a | b;
            4'd5: e.res = a << b[4:0];
            4'd6: e.res = a >> b[4:0];
            4'd7: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd8: e.res = (ua < ub) ? 32'd1 : 32'd0;
            default: e.ill = 1'b1;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    function automatic int model_grant(input logic [NUM_REQ-1:0] vld);
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            int unsigned idx = (m_ptr + off) % NUM_REQ;
            if (vld[idx]) return int'(idx);
        end
        return -1;
    endfunction

    task automatic drive_data();
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            bus.req_a[32*i +: 32] = da[i];
            bus.req_b[32*i +: 32] = db[i];
            bus.req_ctrl[4*i +: 4] = dc[i];
        end
    endtask

    task automatic random_data();
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            da[i] = $urandom;
            db[i] = ($urandom_range(0, 3) == 0) ? da[i] : $urandom;
            dc[i] = 4'($urandom_range(0, 15));
        end
        drive_data();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_ptr = 0;
        m_count = 0;
    endtask

    task automatic add_vec(input int unsigned id, input logic [3:0] ctrl, input logic [31:0] a,
                           input logic [31:0] b, input int unsigned hold, input logic [31:0] res,
                           input logic c, input logic v, input logic z, input logic ill);
        vec_t t;
        t.id = id; t.ctrl = ctrl; t.a = a; t.b = b; t.hold = hold;
        t.ex.res = res; t.ex.c = c; t.ex.v = v; t.ex.z = z; t.ex.ill = ill;
        vecs.push_back(t);
    endtask

    // One full transaction from an idle DUT: handshake, exec, resp (held), accept.
    task automatic serve(input logic [NUM_REQ-1:0] vld, input int g, input exp_t ex,
                         input int unsigned hold, input string tag);
        bus.req_valid = vld;
        #1;
        check({tag, " req_ready"}, 32'(bus.req_ready), 32'(1 << g));
        m_ptr = (32'(g) + 1) % NUM_REQ;
        @(posedge clk); #1;
        // Scramble inputs: only the latched operands may matter from here on.
        bus.req_valid = '1;
        random_data();
        #1;
        check({tag, " exec busy"}, 32'(bus.busy), 32'd1);
        check({tag, " exec rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, " exec req_ready"}, 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, " rsp_id"}, 32'(bus.rsp_id), 32'(g));
        check({tag, " result"}, bus.rsp_result, ex.res);
        check({tag, " carryout"}, 32'(bus.rsp_carryout), 32'(ex.c));
        check({tag, " overflow"}, 32'(bus.rsp_overflow), 32'(ex.v));
        check({tag, " zero"}, 32'(bus.rsp_zero), 32'(ex.z));
        check({tag, " illegal"}, 32'(bus.rsp_illegal), 32'(ex.ill));
        for (int unsigned h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, " hold rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, " hold result"}, bus.rsp_result, ex.res);
            check({tag, " hold req_ready"}, 32'(bus.req_ready), 32'd0);
            check({tag, " hold busy"}, 32'(bus.busy), 32'd1);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        m_count++;
        check({tag, " idle busy"}, 32'(bus.busy), 32'd0);
        check({tag, " idle rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, " op_count"}, bus.op_count, 32'(m_count));
    endtask

    initial begin
        exp_t ex;
        int   g;
        logic [NUM_REQ-1:0] vld;

        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_ctrl = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("reset req_ready", 32'(bus.req_ready), 32'd0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset rsp_result", bus.rsp_result, 32'd0);
        check("reset rsp_id", 32'(bus.rsp_id), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset op_count", bus.op_count, 32'd0);

        // Directed vectors: id, ctrl, a, b, hold, result, carry, overflow, zero, illegal.
        add_vec(0, 4'd0,  32'h7fff_ffff, 32'h7fff_ffff, 0, 32'hffff_fffe, 0, 1, 0, 0);
        add_vec(2, 4'd1,  32'd5,         32'd5,         0, 32'd0,        1, 0, 1, 0);
        add_vec(1, 4'd8,  32'h0000_ffff, 32'hffff_ffff, 0, 32'd1,        0, 0, 0, 0);
        add_vec(2, 4'd1,  32'h8000_0000, 32'd1,         10, 32'h7fff_ffff, 1, 1, 0, 0);
        add_vec(3, 4'd12, 32'd1,         32'd1,         0, 32'd0,        0, 0, 1, 1);
        add_vec(0, 4'd5,  32'd1,         32'h0000_0021, 0, 32'd2,        0, 0, 0, 0);
        add_vec(1, 4'd6,  32'h8000_0000, 32'd31,        0, 32'd1,        0, 0, 0, 0);
        add_vec(2, 4'd7,  32'hffff_ffff, 32'd1,         0, 32'd1,        0, 0, 0, 0);
        add_vec(3, 4'd3,  32'h0000_f0f0, 32'h0000_ff00, 0, 32'h0000_0ff0, 0, 0, 0, 0);
        add_vec(0, 4'd0,  32'hffff_ffff, 32'd1,         0, 32'd0,        1, 0, 1, 0);
        add_vec(1, 4'd2,  32'hff00_ff00, 32'h0f0f_0f0f, 0, 32'h0f00_0f00, 0, 0, 0, 0);
        add_vec(3, 4'd4,  32'd0,         32'd0,         0, 32'd0,        0, 0, 1, 0);

        foreach (vecs[k]) begin
            random_data();
            da[vecs[k].id] = vecs[k].a;
            db[vecs[k].id] = vecs[k].b;
            dc[vecs[k].id] = vecs[k].ctrl;
            drive_data();
            serve(NUM_REQ'(1 << vecs[k].id), int'(vecs[k].id), vecs[k].ex, vecs[k].hold,
                  $sformatf("vec%0d", k));
        end

        // All requesters valid back-to-back with the consumer always ready.
        do_reset();
        check("rr op_count after reset", bus.op_count, 32'd0);
        random_data();
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            g = k % int'(NUM_REQ);
            ex = model_alu(dc[g], da[g], db[g]);
            #1;
            check($sformatf("rr%0d grant", k), 32'(bus.req_ready), 32'(1 << g));
            m_ptr = (32'(g) + 1) % NUM_REQ;
            @(posedge clk); #1;
            check($sformatf("rr%0d exec rsp_valid", k), 32'(bus.rsp_valid), 32'd0);
            @(posedge clk); #1;
            check($sformatf("rr%0d rsp_valid", k), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("rr%0d rsp_id", k), 32'(bus.rsp_id), 32'(g));
            check($sformatf("rr%0d result", k), bus.rsp_result, ex.res);
            @(posedge clk);
            m_count++;
        end
        #1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        check("rr op_count", bus.op_count, 32'd5);
        check("rr busy", 32'(bus.busy), 32'd0);

        // Reset while an op is executing discards it and rewinds the pointer.
        @(posedge clk); #1;
        bus.req_valid = 4'b0010;
        @(posedge clk); #1;
        check("rstexec busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_ptr = 0;
        m_count = 0;
        check("rstexec rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rstexec busy after", 32'(bus.busy), 32'd0);
        check("rstexec op_count", bus.op_count, 32'd0);
        @(posedge clk); #1;
        check("rstexec no late rsp", 32'(bus.rsp_valid), 32'd0);
        random_data();
        g = model_grant(4'b0110);
        ex = model_alu(dc[g], da[g], db[g]);
        serve(4'b0110, g, ex, 0, "rstexec req1");

        // Random traffic against the reference model.
        for (int k = 0; k < 40; k++) begin
            random_data();
            vld = NUM_REQ'($urandom_range(0, 15));
            if (vld == '0) begin
                bus.req_valid = '0;
                #1;
                check("rand idle req_ready", 32'(bus.req_ready), 32'd0);
                @(posedge clk); #1;
                check("rand idle busy", 32'(bus.busy), 32'd0);
            end else begin
                g = model_grant(vld);
                ex = model_alu(dc[g], da[g], db[g]);
                serve(vld, g, ex, $urandom_range(0, 2), $sformatf("rand%0d", k));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
